// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl_if
// Description : Key, move-evaluator and history-command bundle for the
//               Sokoban game controller. The slave side is the controller;
//               the master side is the surrounding core.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_ctrl_if;
    // Debounced single-cycle key pulses
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       key_undo;
    logic       key_restart;
    // Move evaluator and level status
    logic       mv_legal;
    logic       mv_push;
    logic       game_won;
    // Controller results
    logic [1:0] dir;
    logic [1:0] sel;
    logic       game_state_en;
    logic [1:0] undo_avail;
    logic [9:0] step_count;
    logic       busy;

    modport master (
        output key_up, key_down, key_left, key_right, key_undo, key_restart,
        output mv_legal, mv_push, game_won,
        input  dir, sel, game_state_en, undo_avail, step_count, busy
    );

    modport slave (
        input  key_up, key_down, key_left, key_right, key_undo, key_restart,
        input  mv_legal, mv_push, game_won,
        output dir, sel, game_state_en, undo_avail, step_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Sokoban sequencing controller. Turns key pulses into
//               single-cycle history write commands (sel + game_state_en),
//               waits EVAL_CYCLES for the move evaluator, and tracks how many
//               undo snapshots remain valid (max 3).
//               Optional feature macro: STEP_COUNT_EN (saturating step
//               counter; when undefined step_count is tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int EVAL_CYCLES = 1,
    parameter int STEP_MAX    = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    game_ctrl_if.slave gc
);

    localparam logic [2:0] c_st_init   = 3'd0;
    localparam logic [2:0] c_st_idle   = 3'd1;
    localparam logic [2:0] c_st_eval   = 3'd2;
    localparam logic [2:0] c_st_commit = 3'd3;
    localparam logic [2:0] c_st_won    = 3'd4;

    localparam logic [1:0] c_sel_init    = 2'd0;
    localparam logic [1:0] c_sel_box     = 2'd1;
    localparam logic [1:0] c_sel_man     = 2'd2;
    localparam logic [1:0] c_sel_retract = 2'd3;

    localparam logic [2:0] c_eval_last = 3'(EVAL_CYCLES - 1);

    // Reject out-of-range configurations at elaboration
    if (EVAL_CYCLES < 1 || EVAL_CYCLES > 7) begin : g_bad_eval_cycles
        $error("game_ctrl: EVAL_CYCLES must be in 1..7");
    end
    if (STEP_MAX < 1 || STEP_MAX > 1023) begin : g_bad_step_max
        $error("game_ctrl: STEP_MAX must fit in 10 bits");
    end

    logic [2:0] r_state;
    logic [1:0] r_dir;
    logic [1:0] r_sel;
    logic       r_en;
    logic [1:0] r_undo;
    logic [2:0] r_eval_cnt;

    logic       w_dir_key;
    logic [1:0] w_dir_code;

    // Direction key priority: up > down > left > right
    always_comb begin
        w_dir_key  = 1'b1;
        w_dir_code = 2'd0;
        if (gc.key_up) begin
            w_dir_code = 2'd0;
        end else if (gc.key_down) begin
            w_dir_code = 2'd1;
        end else if (gc.key_left) begin
            w_dir_code = 2'd2;
        end else if (gc.key_right) begin
            w_dir_code = 2'd3;
        end else begin
            w_dir_key = 1'b0;
        end
    end

    // Main sequencer; INIT and COMMIT each spend one cycle arming and one
    // cycle with the write enable high, so en is always a clean single pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_init;
            r_dir      <= 2'd0;
            r_sel      <= c_sel_init;
            r_en       <= 1'b0;
            r_undo     <= 2'd0;
            r_eval_cnt <= 3'd0;
        end else begin
            case (r_state)
                c_st_init: begin
                    if (!r_en) begin
                        r_en   <= 1'b1;
                        r_sel  <= c_sel_init;
                        r_undo <= 2'd0;
                    end else begin
                        r_en    <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                c_st_idle: begin
                    // Only the highest-priority key is considered; an undo
                    // with nothing to retract still swallows direction keys
                    if (gc.key_restart) begin
                        r_sel   <= c_sel_init;
                        r_state <= c_st_commit;
                    end else if (gc.key_undo) begin
                        if (r_undo != 2'd0) begin
                            r_sel   <= c_sel_retract;
                            r_state <= c_st_commit;
                        end
                    end else if (w_dir_key) begin
                        r_dir      <= w_dir_code;
                        r_eval_cnt <= 3'd0;
                        r_state    <= c_st_eval;
                    end
                end
                c_st_eval: begin
                    if (r_eval_cnt == c_eval_last) begin
                        if (gc.mv_legal) begin
                            r_sel   <= gc.mv_push ? c_sel_box : c_sel_man;
                            r_state <= c_st_commit;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_eval_cnt <= r_eval_cnt + 3'd1;
                    end
                end
                c_st_commit: begin
                    if (!r_en) begin
                        r_en <= 1'b1;
                        case (r_sel)
                            c_sel_init:    r_undo <= 2'd0;
                            // Undo only enters COMMIT with r_undo > 0
                            c_sel_retract: r_undo <= r_undo - 2'd1;
                            default: begin
                                if (r_undo != 2'd3) begin
                                    r_undo <= r_undo + 2'd1;
                                end
                            end
                        endcase
                    end else begin
                        r_en    <= 1'b0;
                        r_state <= gc.game_won ? c_st_won : c_st_idle;
                    end
                end
                c_st_won: begin
                    if (gc.key_restart) begin
                        r_state <= c_st_init;
                    end else if (!gc.game_won) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_state <= c_st_init;
                end
            endcase
        end
    end

`ifdef STEP_COUNT_EN
    localparam logic [9:0] c_step_max = 10'(STEP_MAX);

    logic [9:0] r_step;
    logic       w_init_fire;
    logic       w_commit_fire;

    assign w_init_fire   = (r_state == c_st_init)   && !r_en;
    assign w_commit_fire = (r_state == c_st_commit) && !r_en;

    // Step counter moves in lockstep with the history write pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= 10'd0;
        end else if (w_init_fire) begin
            r_step <= 10'd0;
        end else if (w_commit_fire) begin
            case (r_sel)
                c_sel_init: r_step <= 10'd0;
                c_sel_retract: begin
                    if (r_step != 10'd0) begin
                        r_step <= r_step - 10'd1;
                    end
                end
                default: begin
                    if (r_step < c_step_max) begin
                        r_step <= r_step + 10'd1;
                    end
                end
            endcase
        end
    end

    assign gc.step_count = r_step;
`else
    assign gc.step_count = 10'd0;
`endif

    assign gc.dir           = r_dir;
    assign gc.sel           = r_sel;
    assign gc.game_state_en = r_en;
    assign gc.undo_avail    = r_undo;
    assign gc.busy          = (r_state != c_st_idle) && (r_state != c_st_won);

endmodule
`default_nettype wire
